// File: rtl/regfile_sb.sv
// Register file with a per-register busy scoreboard and write-to-read bypass.
// After reset, all registers are cleared one per cycle before ready is raised.
module regfile_sb #(
   parameter int XLEN = 32,
   parameter int AW   = 5
) (
   input  logic            clk,
   input  logic            rst,
   output logic            ready,
   input  logic [AW-1:0]   rs1,
   input  logic [AW-1:0]   rs2,
   output logic [XLEN-1:0] rdata1,
   output logic [XLEN-1:0] rdata2,
   output logic            busy1,
   output logic            busy2,
   input  logic            issue_en,
   input  logic [AW-1:0]   issue_rd,
   input  logic            wb_en,
   input  logic [AW-1:0]   wb_rd,
   input  logic [XLEN-1:0] wb_data
);

   localparam int NREG = 2 ** AW;
   localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

   typedef enum logic {CLEAR, RUN} state_t;

   state_t              state_q;
   logic [AW-1:0]       cnt_q;
   logic                ready_q;
   logic [XLEN-1:0]     regs_q [NREG];
   logic [NREG-1:0]     busy_q;
   logic [NREG-1:0]     busy_d;
   logic                wbValid;
   logic                running;

   assign running = (state_q == RUN);
   assign wbValid = wb_en && (wb_rd != '0);
   assign ready   = ready_q;

   // Issue is applied after writeback so a same-index issue keeps the bit set.
   always_comb begin
      busy_d = busy_q;
      if (wbValid) begin
         busy_d[wb_rd] = 1'b0;
      end
      if (issue_en && (issue_rd != '0)) begin
         busy_d[issue_rd] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= CLEAR;
         cnt_q   <= '0;
         ready_q <= 1'b0;
         busy_q  <= '0;
      end else begin
         case (state_q)
            CLEAR: begin
               regs_q[cnt_q] <= '0;
               cnt_q         <= cnt_q + 1'b1;
               if (cnt_q == LAST_IDX) begin
                  state_q <= RUN;
                  ready_q <= 1'b1;
               end
            end
            RUN: begin
               if (wbValid) begin
                  regs_q[wb_rd] <= wb_data;
               end
               busy_q <= busy_d;
            end
            default: begin
               state_q <= CLEAR;
               cnt_q   <= '0;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   // Reads are forced to zero until the clear sequence completes.
   always_comb begin
      rdata1 = '0;
      rdata2 = '0;
      busy1  = 1'b0;
      busy2  = 1'b0;
      if (running && (rs1 != '0)) begin
         rdata1 = (wb_en && (wb_rd == rs1)) ? wb_data : regs_q[rs1];
         busy1  = busy_q[rs1] && !(wb_en && (wb_rd == rs1));
      end
      if (running && (rs2 != '0)) begin
         rdata2 = (wb_en && (wb_rd == rs2)) ? wb_data : regs_q[rs2];
         busy2  = busy_q[rs2] && !(wb_en && (wb_rd == rs2));
      end
   end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter XLEN, default 32, data width in bits.
REQ-002 Parameter AW, default 5, register index width; register count NREG = 2**AW.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 ready  output  1  high when clear sequence is complete and file is operational.
REQ-006 rs1, rs2  input  AW each  read port indices.
REQ-007 rdata1, rdata2  output  XLEN each  read port data (combinational).
REQ-008 busy1, busy2  output  1 each  pending-write flag for rs1/rs2 (combinational).
REQ-009 issue_en  input  1  marks register issue_rd as awaiting writeback.
REQ-010 issue_rd  input  AW  destination index being issued.
REQ-011 wb_en  input  1  writeback strobe.
REQ-012 wb_rd  input  AW  writeback index.
REQ-013 wb_data  input  XLEN  writeback data.

Function
REQ-014 Storage SHALL be NREG x XLEN registers plus NREG busy bits; register 0 SHALL always read 0, never be written, never be busy.
REQ-015 Two-state FSM SHALL be used: CLEAR, RUN; ready = (state == RUN), registered.
REQ-016 In CLEAR, each rst-low cycle SHALL write 0 to x[cnt] and increment cnt; on the cycle cnt == NREG-1 the state SHALL move to RUN.
REQ-017 ready SHALL therefore rise after exactly NREG rising edges with rst low following reset release.
REQ-018 In CLEAR, issue_en and wb_en SHALL be ignored; rdata1/rdata2 SHALL read 0 and busy1/busy2 SHALL read 0.
REQ-019 In RUN, wb_en with wb_rd != 0 SHALL write wb_data to x[wb_rd] at the clock edge.
REQ-020 In RUN, rdataN SHALL equal wb_data when wb_en && wb_rd == rsN && rsN != 0 (write-to-read bypass), else x[rsN].
REQ-021 In RUN, issue_en with issue_rd != 0 SHALL set busy[issue_rd]; wb_en with wb_rd != 0 SHALL clear busy[wb_rd].
REQ-022 Simultaneous issue and writeback to the same nonzero index SHALL leave busy set (issue wins); data is still written.
REQ-023 Simultaneous issue and writeback to different indices SHALL apply both.
REQ-024 busyN SHALL equal busy[rsN] & ~(wb_en && wb_rd == rsN) (bypassed value counts as available); busyN = 0 for rsN = 0.
REQ-025 Writeback to a non-busy register SHALL still write data; no error flag.
REQ-026 Both read ports SHALL operate independently, including rs1 == rs2.

Reset
REQ-027 While rst is high: state <= CLEAR, cnt <= 0, all busy bits <= 0, ready = 0 from the next edge.
REQ-028 rst asserted mid-CLEAR or in RUN SHALL restart the full clear sequence from index 0; register contents not yet cleared are unspecified but SHALL read 0 while ready = 0.

Verification
REQ-029 rst high 2 cycles then low -> ready = 0 for 32 edges, 1 on the 32nd edge; all 32 registers then read 0, busy1 = busy2 = 0.
REQ-030 RUN: wb_en=1, wb_rd=5, wb_data=0xDEADBEEF, rs1=5 same cycle -> rdata1 = 0xDEADBEEF combinationally; next cycle with wb_en=0 rdata1 = 0xDEADBEEF.
REQ-031 issue_en=1, issue_rd=7 -> next cycle rs2=7 gives busy2=1; wb_en=1, wb_rd=7, wb_data=0x12345678 -> busy2=0 in that cycle, rdata2=0x12345678; stays clear afterward.
REQ-032 issue_rd=9 and wb_rd=9 same cycle, wb_data=0xA5A5A5A5 -> next cycle busy[9]=1, x[9]=0xA5A5A5A5.
REQ-033 wb_en=1, wb_rd=0, wb_data=0xFFFFFFFF; issue_en=1, issue_rd=0 -> rs1=0 reads 0, busy1=0, now and next cycle.
REQ-034 In RUN with x[3]=0x55 and busy[3]=1, assert rst 1 cycle -> ready=0, busy1=0 for rs1=3, rdata1=0; after 32 more edges ready=1, x[3]=0.
